// File: rtl/can_id_assembler.sv
// Purpose : bit-serial CAN arbitration-field assembler (standard/extended ID, RTR/IDE/SRR) with mask/ID acceptance filters.
// Latency : ID_VALID and the new IDTFR/IDE/RTR/ID_MATCH/MATCH_IDX appear one clk after the SP of the final field bit.
// Backpressure : none; bits are consumed on SP strobes, and ABORT or SOF may cut a frame short at any time.
module can_id_assembler #(
   parameter int   NUM_FILTERS = 4,
   parameter logic EXT_EN      = 1'b1,
   parameter int   IDXW        = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_sp,
   input  logic                      i_rx_bit,
   input  logic                      i_stuff,
   input  logic                      i_sof,
   input  logic                      i_abort,
   input  logic [NUM_FILTERS-1:0]    i_filt_en,
   input  logic [NUM_FILTERS-1:0]    i_filt_ide,
   input  logic [29*NUM_FILTERS-1:0] i_filt_id,
   input  logic [29*NUM_FILTERS-1:0] i_filt_mask,
   output logic [28:0]               o_idtfr,
   output logic                      o_ide,
   output logic                      o_rtr,
   output logic                      o_id_valid,
   output logic                      o_id_match,
   output logic [IDXW-1:0]           o_match_idx,
   output logic                      o_srr_err,
   output logic                      o_ext_rej,
   output logic                      o_busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BASE = 3'd1,
      S_B12  = 3'd2,
      S_IDEB = 3'd3,
      S_EXT  = 3'd4,
      S_RTRX = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t           r_state;
   state_t           w_next;

   // working capture registers, cleared by SOF/ABORT so partial frames never leak
   logic [4:0]       r_cnt;
   logic [10:0]      r_base;
   logic [17:0]      r_ext;
   logic             r_bit12;
   logic             r_ide_w;
   logic             r_rtr_w;
   logic             r_srr_err;

   // last completed frame, presented whenever no DONE is in progress
   logic [28:0]      r_idtfr;
   logic             r_ide;
   logic             r_rtr;
   logic             r_match;
   logic [IDXW-1:0]  r_idx;

   logic             w_acc;
   logic             w_done;
   logic [28:0]      w_id_asm;
   logic [28:0]      w_cmp_mask;
   logic [NUM_FILTERS-1:0] w_hit;
   logic             w_match;
   logic [IDXW-1:0]  w_idx;

   // a bit only counts when it is a real (non-stuff) sample point
   assign w_acc = i_sp & ~i_stuff;

   // standard frames expose zeros in the extended field and compare only the base bits
   assign w_id_asm   = r_ide_w ? {r_ext, r_base} : {18'd0, r_base};
   assign w_cmp_mask = r_ide_w ? 29'h1FFF_FFFF : 29'h0000_07FF;

   // state register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // next-state: ABORT beats SOF, SOF beats any sample point
   always_comb begin
      w_next = r_state;
      if (i_abort) begin
         w_next = S_IDLE;
      end else if (i_sof) begin
         w_next = S_BASE;
      end else begin
         case (r_state)
            S_IDLE: w_next = S_IDLE;
            S_BASE: if (w_acc && r_cnt == 5'd10) w_next = S_B12;
            S_B12:  if (w_acc) w_next = S_IDEB;
            S_IDEB: if (w_acc) w_next = i_rx_bit ? S_EXT : S_DONE;
            S_EXT:  if (w_acc && r_cnt == 5'd17) w_next = S_RTRX;
            S_RTRX: if (w_acc) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // output decode: DONE presents the freshly assembled frame combinationally, otherwise the held copy
   always_comb begin
      w_done      = (r_state == S_DONE) && !i_abort;
      o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
      o_id_valid  = w_done;
      o_ext_rej   = w_done & r_ide_w & ~EXT_EN;
      o_srr_err   = r_srr_err;
      o_idtfr     = w_done ? w_id_asm : r_idtfr;
      o_ide       = w_done ? r_ide_w  : r_ide;
      o_rtr       = w_done ? r_rtr_w  : r_rtr;
      o_id_match  = w_done ? w_match  : r_match;
      o_match_idx = w_done ? w_idx    : r_idx;
   end

   // shift in identifier bits MSB first and track the field position
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt   <= 5'd0;
         r_base  <= 11'd0;
         r_ext   <= 18'd0;
         r_bit12 <= 1'b0;
         r_ide_w <= 1'b0;
         r_rtr_w <= 1'b0;
      end else if (i_abort || i_sof) begin
         r_cnt   <= 5'd0;
         r_base  <= 11'd0;
         r_ext   <= 18'd0;
         r_bit12 <= 1'b0;
         r_ide_w <= 1'b0;
         r_rtr_w <= 1'b0;
      end else if (w_acc) begin
         case (r_state)
            S_BASE: begin
               r_base <= {r_base[9:0], i_rx_bit};
               r_cnt  <= (r_cnt == 5'd10) ? 5'd0 : r_cnt + 5'd1;
            end
            S_B12: begin
               r_bit12 <= i_rx_bit;
            end
            S_IDEB: begin
               r_ide_w <= i_rx_bit;
               // standard frame: the bit after the base ID was RTR
               if (!i_rx_bit) r_rtr_w <= r_bit12;
            end
            S_EXT: begin
               r_ext <= {r_ext[16:0], i_rx_bit};
               r_cnt <= (r_cnt == 5'd17) ? 5'd0 : r_cnt + 5'd1;
            end
            S_RTRX: begin
               r_rtr_w <= i_rx_bit;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // SRR must be recessive in extended frames; flag a dominant one for one clk and keep capturing
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_srr_err <= 1'b0;
      else          r_srr_err <= !i_abort && !i_sof && w_acc && (r_state == S_IDEB) && i_rx_bit && !r_bit12;
   end

   // acceptance filters, evaluated against the live filter inputs only while in DONE
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_FILTERS; i++) begin
         w_hit[i] = i_filt_en[i]
                  && (i_filt_ide[i] == r_ide_w)
                  && (((w_id_asm ^ i_filt_id[29*i +: 29]) & i_filt_mask[29*i +: 29] & w_cmp_mask) == 29'd0)
                  && !(r_ide_w && !EXT_EN);
      end
   end

   // lowest-index hit wins; index reads 0 when nothing hits
   always_comb begin
      w_match = |w_hit;
      w_idx   = '0;
      for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
         if (w_hit[i]) w_idx = IDXW'(i);
      end
   end

   // hold the completed frame until the next DONE; aborted frames never reach here
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_idtfr <= 29'd0;
         r_ide   <= 1'b0;
         r_rtr   <= 1'b0;
         r_match <= 1'b0;
         r_idx   <= '0;
      end else if (w_done) begin
         r_idtfr <= w_id_asm;
         r_ide   <= r_ide_w;
         r_rtr   <= r_rtr_w;
         r_match <= w_match;
         r_idx   <= w_idx;
      end
   end

endmodule

// File: tb/tb_can_id_assembler.sv
module tb_can_id_assembler;

   logic clk = 1'b0;
   logic rst_n, sp, rx, stuff, sof, abort;
   logic [3:0]  f_en, f_ide;
   logic [28:0] f_id [4];
   logic [28:0] f_mask [4];
   logic [115:0] filt_id_bus, filt_mask_bus;

   logic [28:0] idtfr [2];
   logic        ide [2], rtr [2], vld [2], match [2], srr [2], rej [2], busy [2];
   logic [1:0]  idx [2];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int sof_cyc = 0;
   int vld_cyc = 0;
   int srr_cnt = 0;
   int rej_cnt = 0;

   // expected outputs; [d] = instance with EXT_EN=d
   logic [28:0] exp_idtfr;
   bit exp_ide, exp_rtr, exp_vld, exp_srr, exp_busy;
   bit exp_match [2];
   int exp_idx [2];
   bit exp_rej [2];

   assign filt_id_bus   = {f_id[3], f_id[2], f_id[1], f_id[0]};
   assign filt_mask_bus = {f_mask[3], f_mask[2], f_mask[1], f_mask[0]};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   can_id_assembler #(.NUM_FILTERS(4), .EXT_EN(1'b1)) u_dut1 (
      .i_clk(clk), .i_reset(rst_n), .i_sp(sp), .i_rx_bit(rx), .i_stuff(stuff),
      .i_sof(sof), .i_abort(abort), .i_filt_en(f_en), .i_filt_ide(f_ide),
      .i_filt_id(filt_id_bus), .i_filt_mask(filt_mask_bus),
      .o_idtfr(idtfr[1]), .o_ide(ide[1]), .o_rtr(rtr[1]), .o_id_valid(vld[1]),
      .o_id_match(match[1]), .o_match_idx(idx[1]), .o_srr_err(srr[1]),
      .o_ext_rej(rej[1]), .o_busy(busy[1]));

   can_id_assembler #(.NUM_FILTERS(4), .EXT_EN(1'b0)) u_dut0 (
      .i_clk(clk), .i_reset(rst_n), .i_sp(sp), .i_rx_bit(rx), .i_stuff(stuff),
      .i_sof(sof), .i_abort(abort), .i_filt_en(f_en), .i_filt_ide(f_ide),
      .i_filt_id(filt_id_bus), .i_filt_mask(filt_mask_bus),
      .o_idtfr(idtfr[0]), .o_ide(ide[0]), .o_rtr(rtr[0]), .o_id_valid(vld[0]),
      .o_id_match(match[0]), .o_match_idx(idx[0]), .o_srr_err(srr[0]),
      .o_ext_rej(rej[0]), .o_busy(busy[0]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // acceptance rule: first enabled filter with matching IDE whose masked bits agree
   function automatic void model_filt(input logic [28:0] id, input bit is_ext, input bit ext_en,
                                      output bit m, output int ix);
      logic [28:0] cmp;
      m = 0;
      ix = 0;
      if (is_ext && !ext_en) return;
      for (int i = 0; i < 4; i++) begin
         cmp = is_ext ? f_mask[i] : (f_mask[i] & 29'h7FF);
         if (!m && f_en[i] && (f_ide[i] == is_ext) && (((id ^ f_id[i]) & cmp) == 29'd0)) begin
            m = 1;
            ix = i;
         end
      end
   endfunction

   task automatic zero_exp();
      exp_idtfr = '0; exp_ide = 0; exp_rtr = 0; exp_vld = 0; exp_srr = 0; exp_busy = 0;
      for (int d = 0; d < 2; d++) begin
         exp_match[d] = 0; exp_idx[d] = 0; exp_rej[d] = 0;
      end
   endtask

   task automatic set_filt(input int i, input bit en, input bit fi, input logic [28:0] id, input logic [28:0] mask);
      f_en[i] = en; f_ide[i] = fi; f_id[i] = id; f_mask[i] = mask;
   endtask

   // cut_kind: 1 = ABORT (with a coincident SP) before bit cut_at, 2 = async reset, 3 = leave frame hanging
   task automatic run_frame(input logic [10:0] base, input logic [17:0] ext, input bit is_ext,
                            input bit b12, input bit rtrx, input int stuff_at,
                            input int cut_at, input int cut_kind);
      bit bits[$];
      bit m;
      int ix;
      for (int i = 10; i >= 0; i--) bits.push_back(base[i]);
      bits.push_back(b12);
      bits.push_back(is_ext);
      if (is_ext) begin
         for (int i = 17; i >= 0; i--) bits.push_back(ext[i]);
         bits.push_back(rtrx);
      end
      sof_cyc = cyc;
      // SOF bit carries its own SP, which must not be captured
      sof = 1; sp = 1; rx = 0;
      step();
      sof = 0; sp = 0; exp_busy = 1;
      step();
      for (int k = 0; k < bits.size(); k++) begin
         if (k == cut_at) begin
            if (cut_kind == 1) begin
               abort = 1; sp = 1; rx = 0;
               step();
               abort = 0; sp = 0; exp_busy = 0;
               step();
            end else if (cut_kind == 2) begin
               #2 rst_n = 0;
               zero_exp();
               #1;
               for (int d = 0; d < 2; d++) begin
                  chk($sformatf("rst_async_idtfr%0d", d), idtfr[d], 0);
                  chk($sformatf("rst_async_ide%0d", d), ide[d], 0);
                  chk($sformatf("rst_async_busy%0d", d), busy[d], 0);
               end
               @(posedge clk);
               #1 rst_n = 1;
               step();
            end
            return;
         end
         if (k == stuff_at) begin
            sp = 1; stuff = 1; rx = ~bits[k-1];
            step();
            sp = 0; stuff = 0;
            step();
         end
         sp = 1; rx = bits[k];
         step();
         sp = 0;
         if (k == bits.size() - 1) begin
            exp_idtfr = is_ext ? {ext, base} : {18'd0, base};
            exp_ide   = is_ext;
            exp_rtr   = is_ext ? rtrx : b12;
            exp_vld   = 1;
            exp_busy  = 0;
            for (int d = 0; d < 2; d++) begin
               model_filt(exp_idtfr, is_ext, d[0], m, ix);
               exp_match[d] = m;
               exp_idx[d]   = ix;
            end
            exp_rej[0] = is_ext;
            exp_rej[1] = 0;
            step();
            exp_vld = 0;
            exp_rej[0] = 0;
         end else begin
            if (k == 12 && is_ext && !b12) exp_srr = 1;
            step();
            exp_srr = 0;
         end
      end
   endtask

   // cycle-by-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (vld[1]) vld_cyc = cyc;
      if (srr[1]) srr_cnt++;
      if (rej[0]) rej_cnt++;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("idtfr%0d", d), idtfr[d], exp_idtfr);
         chk($sformatf("ide%0d", d), ide[d], exp_ide);
         chk($sformatf("rtr%0d", d), rtr[d], exp_rtr);
         chk($sformatf("id_valid%0d", d), vld[d], exp_vld);
         chk($sformatf("id_match%0d", d), match[d], exp_match[d]);
         chk($sformatf("match_idx%0d", d), idx[d], exp_idx[d]);
         chk($sformatf("srr_err%0d", d), srr[d], exp_srr);
         chk($sformatf("ext_rej%0d", d), rej[d], exp_rej[d]);
         chk($sformatf("busy%0d", d), busy[d], exp_busy);
      end
   end

   initial begin
      int d1, d2;
      zero_exp();
      rst_n = 1; sp = 0; rx = 1; stuff = 0; sof = 0; abort = 0;
      for (int i = 0; i < 4; i++) set_filt(i, 0, 0, '0, '0);
      #1 rst_n = 0;
      repeat (3) step();
      chk("reset_idtfr", idtfr[1], 0);
      chk("reset_busy", busy[1], 0);
      chk("reset_match", match[1], 0);
      rst_n = 1;
      step();

      // standard 0x5A3, exact filter 0
      set_filt(0, 1, 0, 29'h5A3, 29'h7FF);
      run_frame(11'h5A3, 18'h0, 0, 0, 0, -1, -1, 0);
      chk("t1_idtfr", idtfr[1], 29'h00005A3);
      chk("t1_match", match[1], 1);
      chk("t1_idx", idx[1], 0);
      chk("t1_latency", vld_cyc - sof_cyc, 27);

      // extended, only filter 2 (mask 0, IDE=1) live
      set_filt(0, 0, 0, 29'h5A3, 29'h7FF);
      set_filt(2, 1, 1, 29'h0, 29'h0);
      run_frame(11'h123, 18'h2ABCD, 1, 1, 1, -1, -1, 0);
      chk("t2_idtfr", idtfr[1], 29'h155E6923);
      chk("t2_idx", idx[1], 2);
      chk("t2_rtr", rtr[1], 1);
      chk("t2_extrej_match", match[0], 0);

      // dominant SRR
      run_frame(11'h123, 18'h2ABCD, 1, 0, 1, -1, -1, 0);
      chk("t3_srr_pulses", srr_cnt, 1);
      chk("t3_rej_pulses", rej_cnt, 2);
      chk("t3_rej_idtfr", idtfr[0], 29'h155E6923);

      // stuff bit after five recessive base bits
      set_filt(3, 1, 0, 29'h7C0, 29'h7F0);
      run_frame(11'h7C3, 18'h0, 0, 0, 0, -1, -1, 0);
      d1 = vld_cyc - sof_cyc;
      run_frame(11'h7C3, 18'h0, 0, 0, 0, 5, -1, 0);
      d2 = vld_cyc - sof_cyc;
      chk("t4_stuff_shift", d2 - d1, 2);
      chk("t4_idtfr", idtfr[1], 29'h7C3);
      chk("t4_idx", idx[1], 3);

      // abort after 7 base bits, then ID 0x001 (upper filter bits must be ignored)
      set_filt(0, 1, 0, 29'h1FFFF801, 29'h1FFFFFFF);
      run_frame(11'h155, 18'h0, 0, 0, 0, -1, 7, 1);
      chk("t5_held_idtfr", idtfr[1], 29'h7C3);
      run_frame(11'h001, 18'h0, 0, 1, 0, -1, -1, 0);
      chk("t5_idtfr", idtfr[1], 29'h0000001);
      chk("t5_idx", idx[1], 0);
      chk("t5_rtr", rtr[1], 1);

      // SOF while busy restarts capture
      run_frame(11'h2AA, 18'h0, 0, 0, 0, -1, 4, 3);
      run_frame(11'h0F0, 18'h0, 0, 0, 0, -1, -1, 0);
      chk("t7_idtfr", idtfr[1], 29'h0F0);
      chk("t7_nomatch", match[1], 0);

      // reset mid-EXT, then all-ones extended frame
      set_filt(1, 1, 1, 29'h1FFFF800, 29'h1FFFF800);
      run_frame(11'h7FF, 18'h3FFFF, 1, 1, 0, -1, 20, 2);
      run_frame(11'h7FF, 18'h3FFFF, 1, 1, 0, -1, -1, 0);
      chk("t6_idtfr", idtfr[1], 29'h1FFFFFFF);
      chk("t6_idx", idx[1], 1);
      chk("t6_rtr", rtr[1], 0);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/can_id_assembler.md
Name: can_id_assembler

Overview:
- Parametrised successor to the frame identifier register.
- Assembles the CAN arbitration field bit-serially from destuffed sample-point bits.
- Supports standard (11-bit) and extended (29-bit) frames and decodes RTR/IDE/SRR.
- Runs the identifier against NUM_FILTERS mask/ID acceptance filters; sits between the bit destuffer and the frame control FSM.

Parameters:
- NUM_FILTERS, 4: acceptance filter count, 1..16.
- EXT_EN, 1: when 0, extended frames are parsed but never accepted (EXT_REJ pulses).
- IDXW, $clog2(NUM_FILTERS) min 1: width of MATCH_IDX.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- SP  in  1  sample-point strobe, one clk wide
- RX_BIT  in  1  sampled bus bit (0 = dominant), qualified by SP
- STUFF  in  1  high with SP when the current bit is a stuff bit; that bit is ignored
- SOF  in  1  start-of-frame pulse; arms capture
- ABORT  in  1  error/arbitration loss; abandons capture
- FILT_EN  in  NUM_FILTERS  per-filter enable
- FILT_IDE  in  NUM_FILTERS  required IDE value per filter
- FILT_ID  in  29*NUM_FILTERS  filter i at [29i+28:29i]
- FILT_MASK  in  29*NUM_FILTERS  1 = bit compared
- IDTFR  out  29  assembled identifier
- IDE  out  1  frame format of IDTFR
- RTR  out  1  remote request flag
- ID_VALID  out  1  one-clk pulse, identifier complete
- ID_MATCH  out  1  accepted by at least one filter; valid with ID_VALID, held after
- MATCH_IDX  out  IDXW  lowest matching filter index, 0 if none
- SRR_ERR  out  1  one-clk pulse, SRR sampled dominant in extended frame
- EXT_REJ  out  1  one-clk pulse, extended frame seen with EXT_EN=0
- BUSY  out  1  high in any state other than IDLE/DONE

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; shift register and bit counter 0.
- Accepted bit: SP=1 and STUFF=0. All state advances happen only on accepted bits except SOF/ABORT/DONE.
- Identifier layout: base ID in IDTFR[10:0], extended ID in IDTFR[28:11]; standard frames force [28:11]=0. Bits arrive MSB first.
- FSM:
  - IDLE: SOF -> BASE, counter=0.
  - BASE: 11 accepted bits into base[10:0] -> B12.
  - B12: captures bit12 (RTR for standard, SRR for extended) -> IDEB.
  - IDEB: IDE=0 -> DONE with RTR=bit12. IDE=1 -> EXT; pulse SRR_ERR if bit12==0 (capture continues).
  - EXT: 18 accepted bits into ext[17:0] -> RTRX.
  - RTRX: RTR=bit -> DONE.
  - DONE: one clk. Registers IDTFR/IDE/RTR/ID_MATCH/MATCH_IDX, pulses ID_VALID (and EXT_REJ if IDE=1 and EXT_EN=0), then -> IDLE.
- Latency: ID_VALID is high exactly one clk after the clk holding the SP of the final field bit (IDE bit or extended RTR bit).
- Filter i hits when all hold:
  - FILT_EN[i] = 1
  - FILT_IDE[i] == IDE
  - ((IDTFR ^ FILT_ID[i]) & FILT_MASK[i]) == 0
  - For standard frames only bits [10:0] are compared.
  - EXT_EN=0 forces no hit for IDE=1.
  - MATCH_IDX is the lowest hit index.
- Filter inputs are sampled only in DONE; changing them mid-frame is legal.
- Outputs IDTFR/IDE/RTR/ID_MATCH/MATCH_IDX hold their last completed value until the next DONE. Aborted frames never update them.
- ABORT in any state -> IDLE next clk, no pulses, working shift register cleared. ABORT beats SOF and SP in the same clk.
- SOF while BUSY restarts capture at BASE, counter=0, with partial data discarded.
- SOF coincident with SP: that SP is the SOF bit itself and is not captured; capture begins at the next accepted bit.
- SP with STUFF=1 does not advance the counter in any state.
- Counter is 5 bits and compared with ==10 and ==17 for field end; no wrap is possible.

Test Plan:
- Standard frame, ID=0x5A3, RTR=0, IDE=0; filter0 ID=0x5A3 mask=0x7FF IDE=0 -> ID_VALID 1 clk after IDE SP; IDTFR=0x00005A3, IDE=0, RTR=0, ID_MATCH=1, MATCH_IDX=0.
- Extended frame, base=0x123, ext=0x2ABCD, SRR=1, RTR=1; filter2 mask=0 IDE=1, filters0/1 disabled -> IDTFR={0x2ABCD,0x123}=0x155E6923, IDE=1, RTR=1, MATCH_IDX=2, no SRR_ERR.
- Same extended frame with SRR=0 and EXT_EN=0 -> SRR_ERR pulse after IDE bit; ID_VALID and EXT_REJ pulse together; ID_MATCH=0; IDTFR still updated.
- Stuff bit (STUFF=1) inserted after 5 equal base bits -> IDTFR unchanged versus the unstuffed run, and ID_VALID timing shifted by exactly one SP.
- ABORT after 7 base bits, then a new SOF with standard ID 0x001 -> no ID_VALID for the aborted frame; the prior IDTFR is held until the new DONE, then IDTFR=0x0000001.
- reset asserted mid-EXT -> all outputs 0 immediately (asynchronous); after release, SOF+frame decodes normally.
